uart_tx: RTL and testbench

- Serial UART transmitter.
- Sits directly downstream of the clock-domain-crossing FIFO's destination side.
- Pops one parallel word per valid/ready handshake and shifts it out on a single line as one frame:
  - start bit
  - DATA_WIDTH data bits, LSB first
  - optional parity bit
  - STOP_BITS stop bits
- Runs entirely in the peripheral (destination) clock domain.

---
 rtl/uart_tx_if.sv | 23 ++
 rtl/uart_tx.sv | 154 +++++++++++++++
 tb/tb_uart_tx.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Word handshake into the UART transmitter. The producer drives data_in and
// data_valid_in, and the transmitter drives tx_ready_out.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  // A word moves on a rising clock edge where data_valid_in && tx_ready_out are both high.
  // At any other time, data_in and data_valid_in are ignored. tx_ready_out does not depend on data_valid_in.
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid_in;
  logic                  tx_ready_out;

  modport master (
    output data_in,
    output data_valid_in,
    input  tx_ready_out
  );

  modport slave (
    input  data_in,
    input  data_valid_in,
    output tx_ready_out
  );
endinterface

// File: rtl/uart_tx.sv
// Serial UART transmitter. It takes one word per handshake and sends a start bit,
// the data bits LSB first, an optional parity bit and then the stop bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_in,
  input  logic       rst_high_in,
  uart_tx_if.slave   bus,
  output logic       tx_out,
  output logic       busy_out,
  output logic [2:0] state_dbg_out
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
    $error("uart_tx: DATA_WIDTH must be in 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
    $error("uart_tx: PARITY_EN must be 0 or 1");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic             ODD_SEL   = (PARITY_ODD != 0);
  localparam bit               HAS_PAR   = (PARITY_EN != 0);

  logic [2:0]            state;
  logic [CNT_W-1:0]      baud_cnt;
  logic [3:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  parity_bit;
  logic                  xfer;
  logic                  bit_done;

  // Reset gates ready, so a word that is valid while reset releases is not taken on that edge.
  assign bus.tx_ready_out = (state == S_IDLE) && !rst_high_in;
  assign xfer             = bus.data_valid_in && bus.tx_ready_out;
  assign bit_done         = (baud_cnt == BAUD_LAST);
  assign state_dbg_out    = state;

  // tx_out is loaded on the same edge that changes state, so the line changes on each bit boundary with no extra cycle of delay.
  always_ff @(posedge clk_in or posedge rst_high_in) begin
    if (rst_high_in) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx_out     <= 1'b1;
      busy_out   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (xfer) begin
            state      <= S_START;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= bus.data_in;
            parity_bit <= (^bus.data_in) ^ ODD_SEL;
            tx_out     <= 1'b0;
            busy_out   <= 1'b1;
          end
        end

        S_START: begin
          if (bit_done) begin
            state    <= S_DATA;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_out   <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_done) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (HAS_PAR) begin
                state  <= S_PARITY;
                tx_out <= parity_bit;
              end else begin
                state  <= S_STOP;
                tx_out <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              tx_out  <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (bit_done) begin
            state    <= S_STOP;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_out   <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_STOP: begin
          // bit_cnt counts the stop bits that have finished.
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              state    <= S_IDLE;
              bit_cnt  <= '0;
              busy_out <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx_out   <= 1'b1;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with four configurations: plain, even parity, odd parity and two stop bits.
// A single monitor process rebuilds every frame from the line and compares it against the expected frames queued by the stimulus.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int N   = 4;

  typedef struct packed {
    logic [1:0]  inst;
    logic [7:0]  gap;
    logic [4:0]  nbits;
    logic [15:0] bits;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_v  [N];
  logic       valid_v [N];
  logic       ready_v [N];
  logic       tx_v    [N];
  logic       busy_v  [N];
  logic [2:0] state_v [N];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   finish_req = 1'b0;
  bit   rst_prev = 1'b1;

  logic [63:0] wave_a [N] = '{default: '0};
  int          len_a  [N] = '{default: 0};
  int          gap_a  [N] = '{default: 0};
  int          last_a [N] = '{default: 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : u
    uart_tx_if #(.DATA_WIDTH(8)) bus ();
    assign bus.data_in       = data_v[g];
    assign bus.data_valid_in = valid_v[g];
    assign ready_v[g]        = bus.tx_ready_out;

    uart_tx #(
      .CLKS_PER_BIT (CPB),
      .DATA_WIDTH   (8),
      .PARITY_EN    ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD   ((g == 2) ? 1 : 0),
      .STOP_BITS    ((g == 3) ? 2 : 1)
    ) dut (
      .clk_in        (clk),
      .rst_high_in   (rst),
      .bus           (bus.slave),
      .tx_out        (tx_v[g]),
      .busy_out      (busy_v[g]),
      .state_dbg_out (state_v[g])
    );
  end

  // Scoreboard check for one finished frame. The expected waveform is each queued bit held for CPB cycles.
  task automatic check_frame(input int g, input logic [63:0] w, input int len);
    exp_t        e;
    logic [63:0] ew;
    int          f;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_frame inst=%0d len=%0d wave=%h, no frame expected", g, len, w);
      return;
    end
    e  = exp_q.pop_front();
    f  = int'(e.nbits) * CPB;
    ew = '0;
    for (int k = 0; k < f && k < 64; k++) ew[k] = e.bits[k / CPB];
    if (int'(e.inst) != g || len != f || w !== ew) begin
      errors++;
      $display("FAIL frame inst=%0d len=%0d wave=%h, need inst=%0d len=%0d wave=%h",
               g, len, w, e.inst, f, ew);
    end
    checks++;
    if (ready_v[g] !== 1'b1) begin
      errors++;
      $display("FAIL ready_return inst=%0d ready=%b, need 1 at frame end", g, ready_v[g]);
    end
    if (e.gap != 0) begin
      checks++;
      if (gap_a[g] != int'(e.gap)) begin
        errors++;
        $display("FAIL transfer_gap inst=%0d gap=%0d, need %0d", g, gap_a[g], e.gap);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (rst) begin
        checks++;
        if (tx_v[g] !== 1'b1 || busy_v[g] !== 1'b0 || ready_v[g] !== 1'b0 || state_v[g] !== 3'd0) begin
          errors++;
          $display("FAIL reset_state inst=%0d tx=%b busy=%b ready=%b state=%0d, need 1/0/0/0",
                   g, tx_v[g], busy_v[g], ready_v[g], state_v[g]);
        end
        len_a[g]  = 0;
        wave_a[g] = '0;
      end else begin
        if (rst_prev) begin
          checks++;
          if (ready_v[g] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset inst=%0d ready=%b, need 1", g, ready_v[g]);
          end
        end
        if (busy_v[g] === 1'b1) begin
          checks++;
          if (ready_v[g] !== 1'b0) begin
            errors++;
            $display("FAIL ready_while_busy inst=%0d ready=%b, need 0", g, ready_v[g]);
          end
          if (len_a[g] < 64) wave_a[g][len_a[g]] = tx_v[g];
          len_a[g]++;
        end else begin
          checks++;
          if (tx_v[g] !== 1'b1) begin
            errors++;
            $display("FAIL idle_line inst=%0d tx=%b, need 1", g, tx_v[g]);
          end
          if (len_a[g] > 0) begin
            check_frame(g, wave_a[g], len_a[g]);
            len_a[g]  = 0;
            wave_a[g] = '0;
          end
          if (valid_v[g] === 1'b1 && ready_v[g] === 1'b1) begin
            gap_a[g]  = cyc - last_a[g];
            last_a[g] = cyc;
          end
        end
      end
    end
    rst_prev = rst;
    if (finish_req) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL pending_frames count=%0d, need 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic send(input int i, input logic [7:0] w, input logic [15:0] bits, input int nb,
                      input int gap, input bit hold, input bit expect_it);
    exp_t e;
    int   n;
    data_v[i]  = w;
    valid_v[i] = 1'b1;
    if (expect_it) begin
      e.inst  = 2'(i);
      e.gap   = 8'(gap);
      e.nbits = 5'(nb);
      e.bits  = bits;
      exp_q.push_back(e);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready_v[i] !== 1'b1 && n < 200);
    if (ready_v[i] !== 1'b1) begin
      $display("FAIL send_timeout inst=%0d ready=%b, need 1 within 200 cycles", i, ready_v[i]);
      $fatal(1, "transmitter never became ready");
    end
    @(posedge clk);
    #1;
    if (!hold) valid_v[i] = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      data_v[i]  = '0;
      valid_v[i] = 1'b0;
    end
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);

    // basic frame
    send(0, 8'hA5, 16'(10'b1_1010_0101_0), 10, 0, 1'b0, 1'b1);
    wait_cycles(50);

    // back-to-back with valid held high
    send(0, 8'h00, 16'(10'b1_0000_0000_0), 10, 0, 1'b1, 1'b1);
    send(0, 8'hFF, 16'(10'b1_1111_1111_0), 10, 41, 1'b0, 1'b1);
    wait_cycles(50);

    // even and odd parity
    send(1, 8'h07, 16'(11'b1_1_0000_0111_0), 11, 0, 1'b0, 1'b1);
    wait_cycles(50);
    send(1, 8'h03, 16'(11'b1_0_0000_0011_0), 11, 0, 1'b0, 1'b1);
    wait_cycles(50);
    send(2, 8'h07, 16'(11'b1_0_0000_0111_0), 11, 0, 1'b0, 1'b1);
    wait_cycles(50);
    send(2, 8'h03, 16'(11'b1_1_0000_0011_0), 11, 0, 1'b0, 1'b1);
    wait_cycles(50);

    // two stop bits
    send(3, 8'h3C, 16'(11'b11_0011_1100_0), 11, 0, 1'b0, 1'b1);
    wait_cycles(50);

    // data_in changes every cycle during the frame
    send(0, 8'hC3, 16'(10'b1_1100_0011_0), 10, 0, 1'b0, 1'b1);
    repeat (45) begin
      @(posedge clk);
      #1;
      data_v[0] = 8'($urandom_range(0, 255));
    end
    wait_cycles(5);

    // reset during data bit 3 of 0x55, then a clean 0x81
    send(0, 8'h55, 16'h0000, 10, 0, 1'b0, 1'b0);
    repeat (17) @(posedge clk);
    #1;
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);
    send(0, 8'h81, 16'(10'b1_1000_0001_0), 10, 0, 1'b0, 1'b1);
    wait_cycles(50);

    finish_req = 1'b1;
  end

endmodule
